// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receive parser.
package uart_frame_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    E_NONE = 2'b00,
    E_LEN  = 2'b01,
    E_CHK  = 2'b10,
    E_TMO  = 2'b11
  } err_t;

  // Running frame checksum: XOR of CMD, LEN and payload bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: clear has priority, counts when enabled, holds at terminal count.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_r;

  assign tc = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Count register, saturating at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !tc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser [SOF CMD LEN PAYLOAD.. CHK] feeding the matrix load buffer.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [7:0]        RxData,
  input  logic              RxDone,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [7:0]        WrData,
  output logic [7:0]        Cmd,
  output logic [7:0]        Len,
  output logic              FrameValid,
  output logic              FrameErr,
  output logic [1:0]        ErrCode,
  output logic              Busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            state_r, state_n;
  logic              rx_done_q_r;
  logic              ev_s;
  logic              tmo_hit_s;
  logic [7:0]        chk_r, chk_n;
  logic [7:0]        idx_r, idx_n;
  logic [7:0]        cmd_r, cmd_n;
  logic [7:0]        len_r, len_n;
  logic              wr_en_n, valid_n, err_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n, cmd_out_n, len_out_n;
  logic [1:0]        err_code_n;

  assign ev_s = RxDone & ~rx_done_q_r;

`ifdef UART_FRAME_TIMEOUT_EN
  logic tc_s;

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (ev_s | (state_r == S_IDLE)),
    .en    (1'b1),
    .tc    (tc_s)
  );

  assign tmo_hit_s = tc_s & (state_r != S_IDLE);
`else
  // No timer in this build; the comparison is constant false.
  assign tmo_hit_s = (TIMEOUT_CYC < 0);
`endif

  // Next-state, checksum/index bookkeeping and next output values.
  always_comb begin
    state_n    = state_r;
    chk_n      = chk_r;
    idx_n      = idx_r;
    cmd_n      = cmd_r;
    len_n      = len_r;
    wr_en_n    = 1'b0;
    wr_addr_n  = WrAddr;
    wr_data_n  = WrData;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    err_code_n = ErrCode;
    cmd_out_n  = Cmd;
    len_out_n  = Len;
    if (ev_s) begin
      case (state_r)
        S_IDLE: begin
          if (RxData == SOF) begin
            state_n = S_CMD;
            chk_n   = 8'h00;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_CMD: begin
          cmd_n   = RxData;
          chk_n   = chk_fold(chk_r, RxData);
          state_n = S_LEN;
        end
        S_LEN: begin
          if ((RxData == 8'h00) || (RxData > MAX_LEN_B)) begin
            err_n      = 1'b1;
            err_code_n = E_LEN;
            state_n    = S_IDLE;
          end else begin
            len_n   = RxData;
            chk_n   = chk_fold(chk_r, RxData);
            idx_n   = 8'h00;
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          wr_en_n   = 1'b1;
          wr_addr_n = idx_r[ADDR_W-1:0];
          wr_data_n = RxData;
          chk_n     = chk_fold(chk_r, RxData);
          idx_n     = idx_r + 8'd1;
          if (idx_r == (len_r - 8'd1)) begin
            state_n = S_CHK;
          end else begin
            state_n = S_DATA;
          end
        end
        S_CHK: begin
          if (RxData == chk_r) begin
            valid_n   = 1'b1;
            cmd_out_n = cmd_r;
            len_out_n = len_r;
          end else begin
            err_n      = 1'b1;
            err_code_n = E_CHK;
          end
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end else if (tmo_hit_s) begin
      err_n      = 1'b1;
      err_code_n = E_TMO;
      state_n    = S_IDLE;
    end else begin
      state_n = state_r;
    end
  end

  // State, parser context and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= S_IDLE;
      rx_done_q_r <= 1'b0;
      chk_r       <= 8'h00;
      idx_r       <= 8'h00;
      cmd_r       <= 8'h00;
      len_r       <= 8'h00;
      WrEn        <= 1'b0;
      WrAddr      <= '0;
      WrData      <= 8'h00;
      Cmd         <= 8'h00;
      Len         <= 8'h00;
      FrameValid  <= 1'b0;
      FrameErr    <= 1'b0;
      ErrCode     <= 2'b00;
      Busy        <= 1'b0;
    end else begin
      state_r     <= state_n;
      rx_done_q_r <= RxDone;
      chk_r       <= chk_n;
      idx_r       <= idx_n;
      cmd_r       <= cmd_n;
      len_r       <= len_n;
      WrEn        <= wr_en_n;
      WrAddr      <= wr_addr_n;
      WrData      <= wr_data_n;
      Cmd         <= cmd_out_n;
      Len         <= len_out_n;
      FrameValid  <= valid_n;
      FrameErr    <= err_n;
      ErrCode     <= err_code_n;
      Busy        <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus random frames against a frame-level model.
// The timeout step runs only when UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [7:0]        RxData;
  logic              RxDone;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [7:0]        WrData;
  logic [7:0]        Cmd;
  logic [7:0]        Len;
  logic              FrameValid;
  logic              FrameErr;
  logic [1:0]        ErrCode;
  logic              Busy;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RxData(RxData), .RxDone(RxDone),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Cmd(Cmd), .Len(Len),
    .FrameValid(FrameValid), .FrameErr(FrameErr), .ErrCode(ErrCode), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Monitor: log every write and count frame pulses, sampled on the falling edge.
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [7:0]        wr_data_log[$];
  int                n_valid = 0;
  int                n_err   = 0;

  always @(negedge Clk) begin
    if (WrEn) begin
      wr_addr_log.push_back(WrAddr);
      wr_data_log.push_back(WrData);
    end
    if (FrameValid) n_valid++;
    if (FrameErr) n_err++;
  end

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_cmd  = 8'h00;
  logic [7:0] exp_len  = 8'h00;
  logic [1:0] exp_code = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge Clk);
    RxData = b;
    RxDone = 1'b1;
    repeat (hold) @(negedge Clk);
    RxDone = 1'b0;
    repeat (gap - 1) @(negedge Clk);
  endtask

  // Send one frame and check the outcome predicted from the frame rules.
  task automatic do_frame(input logic [7:0] noise[$], input logic [7:0] cmd, input logic [7:0] len,
                          input logic [7:0] pl[$], input logic [7:0] chk, input int hold);
    int         w0, v0, e0, nw, ev, ee;
    logic       ok_len;
    logic [7:0] x;
    w0 = wr_addr_log.size();
    v0 = n_valid;
    e0 = n_err;
    ok_len = (len != 8'd0) && (int'(len) <= MAX_LEN);
    foreach (noise[i]) send_byte(noise[i], hold, $urandom_range(1, 3));
    send_byte(8'hA5, hold, $urandom_range(1, 3));
    send_byte(cmd, hold, $urandom_range(1, 3));
    send_byte(len, hold, $urandom_range(1, 3));
    if (ok_len) begin
      foreach (pl[i]) send_byte(pl[i], hold, $urandom_range(1, 3));
      send_byte(chk, hold, $urandom_range(1, 3));
    end
    repeat (3) @(negedge Clk);
    nw = 0; ev = 0; ee = 0;
    if (!ok_len) begin
      ee = 1;
      exp_code = 2'b01;
    end else begin
      nw = int'(len);
      x = cmd ^ len;
      foreach (pl[i]) x = x ^ pl[i];
      if (chk == x) begin
        ev = 1;
        exp_cmd = cmd;
        exp_len = len;
      end else begin
        ee = 1;
        exp_code = 2'b10;
      end
    end
    check("wr_count", wr_addr_log.size() - w0, nw);
    for (int i = 0; i < nw; i++) begin
      if (w0 + i < wr_addr_log.size()) begin
        check("wr_addr", wr_addr_log[w0 + i], i);
        check("wr_data", wr_data_log[w0 + i], pl[i]);
      end
    end
    check("frame_valid", n_valid - v0, ev);
    check("frame_err", n_err - e0, ee);
    check("err_code", ErrCode, exp_code);
    check("cmd", Cmd, exp_cmd);
    check("len", Len, exp_len);
    check("busy", Busy, 1'b0);
  endtask

  initial begin
    logic [7:0] noise[$];
    logic [7:0] pl[$];
    logic [7:0] cmd, len, x, chk, b;
    int         r, e0;

    Rst_n  = 1'b0;
    RxDone = 1'b0;
    RxData = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_wren", WrEn, 1'b0);
    check("rst_valid", FrameValid, 1'b0);
    check("rst_err", FrameErr, 1'b0);
    check("rst_errcode", ErrCode, 2'b00);
    check("rst_cmd", Cmd, 8'h00);
    check("rst_len", Len, 8'h00);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Good frame, then bad checksum (Cmd/Len must stay at 03/02).
    noise = {};
    pl = {8'h11, 8'h22};
    do_frame(noise, 8'h03, 8'h02, pl, 8'h32, 1);
    check("good_cmd_03", Cmd, 8'h03);
    check("good_len_02", Len, 8'h02);
    do_frame(noise, 8'h03, 8'h02, pl, 8'h00, 1);
    check("badchk_code", ErrCode, 2'b10);

    // Bad lengths: 0 and MAX_LEN+1.
    pl = {};
    do_frame(noise, 8'h07, 8'h00, pl, 8'h00, 1);
    do_frame(noise, 8'h07, 8'd17, pl, 8'h00, 1);
    check("badlen_code", ErrCode, 2'b01);

    // Noise then frame whose payload and checksum are A5.
    noise = {8'h00, 8'hFF, 8'h5A};
    pl = {8'hA5};
    do_frame(noise, 8'h01, 8'h01, pl, 8'hA5, 1);
    check("noise_cmd", Cmd, 8'h01);

    // RxDone held 50 cycles per byte: still one event each; max-length frame.
    noise = {};
    pl = {8'h5C};
    do_frame(noise, 8'h44, 8'h01, pl, 8'h44 ^ 8'h01 ^ 8'h5C, 50);
    pl = {};
    x = 8'h99 ^ 8'd16;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 17 + 3);
      pl.push_back(b);
      x = x ^ b;
    end
    do_frame(noise, 8'h99, 8'd16, pl, x, 1);

    // Random frames.
    for (int it = 0; it < 30; it++) begin
      noise = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        noise.push_back(b);
      end
      r = $urandom_range(0, 9);
      if (r == 0) len = 8'd0;
      else if (r == 1) len = 8'($urandom_range(17, 255));
      else len = 8'($urandom_range(1, MAX_LEN));
      cmd = 8'($urandom);
      pl = {};
      x = cmd ^ len;
      if (int'(len) >= 1 && int'(len) <= MAX_LEN) begin
        for (int i = 0; i < int'(len); i++) begin
          b = 8'($urandom);
          pl.push_back(b);
          x = x ^ b;
        end
      end
      chk = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
      do_frame(noise, cmd, len, pl, chk, $urandom_range(1, 4));
    end

`ifdef UART_FRAME_TIMEOUT_EN
    // Stalled frame after CMD must time out.
    e0 = n_err;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h03, 1, 1);
    repeat (120) @(negedge Clk);
    check("tmo_err", n_err - e0, 1);
    check("tmo_code", ErrCode, 2'b11);
    check("tmo_busy", Busy, 1'b0);
`endif

    // Reset mid-payload: outputs clear at once, no FrameErr.
    e0 = n_err;
    send_byte(8'hA5, 1, 2);
    send_byte(8'h01, 1, 2);
    send_byte(8'h04, 1, 2);
    send_byte(8'h11, 1, 2);
    send_byte(8'h22, 1, 1);
    check("mid_busy", Busy, 1'b1);
    Rst_n = 1'b0;
    #1;
    check("mrst_busy", Busy, 1'b0);
    check("mrst_wren", WrEn, 1'b0);
    check("mrst_wraddr", WrAddr, 4'h0);
    check("mrst_wrdata", WrData, 8'h00);
    check("mrst_cmd", Cmd, 8'h00);
    check("mrst_len", Len, 8'h00);
    check("mrst_valid", FrameValid, 1'b0);
    check("mrst_errcode", ErrCode, 2'b00);
    repeat (3) @(negedge Clk);
    check("mrst_no_err", n_err - e0, 0);
    Rst_n = 1'b1;
    exp_cmd = 8'h00;
    exp_len = 8'h00;
    exp_code = 2'b00;
    repeat (2) @(negedge Clk);

    // Parser is usable again after reset.
    noise = {};
    pl = {8'h11, 8'h22};
    do_frame(noise, 8'h03, 8'h02, pl, 8'h32, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
